retire_trace_fifo: RTL and testbench

- Sits directly downstream of RISCV_Single_Cycle and consumes its PC_out_top / Instruction_out_top pair every clock.
- Buffers each retired (PC, instruction) pair, with a sequence number, in a FIFO that a bench or debug port drains through a valid/ready handshake.
- Detects the self-loop halt idiom (jal x0,0 = 32'h0000006F) and freezes capture.
- Counts entries lost to overflow.

---
 rtl/retire_trace_fifo.sv | 133 +++++++++++++
 tb/tb_retire_trace_fifo.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/retire_trace_fifo.sv
`default_nettype none
// ============================================================================
// Module   : retire_trace_fifo
// Purpose  : Buffers retired (PC, instruction, seq) tuples behind a valid/ready
//            drain port; freezes capture on the halt idiom, counts overflow.
// Revision : 1.0
// ============================================================================
module retire_trace_fifo #(
  parameter int          DEPTH     = 16,
  parameter int          AW        = 4,
  parameter logic [31:0] HALT_INST = 32'h0000006F
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [31:0]   pc_in,
  input  logic [31:0]   inst_in,
  input  logic          cap_en,
  input  logic          clear,
  input  logic          rd_ready,
  output logic          rd_valid,
  output logic [31:0]   rd_pc,
  output logic [31:0]   rd_inst,
  output logic [15:0]   rd_seq,
  output logic [AW:0]   count,
  output logic          full,
  output logic [15:0]   drop_cnt,
  output logic          halted
);

  localparam logic [1:0]  c_st_armed  = 2'd0;
  localparam logic [1:0]  c_st_run    = 2'd1;
  localparam logic [1:0]  c_st_halted = 2'd2;
  localparam logic [AW:0] c_depth     = (AW+1)'(DEPTH);

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic [31:0]   r_mem_pc   [DEPTH];
  logic [31:0]   r_mem_inst [DEPTH];
  logic [15:0]   r_mem_seq  [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [15:0]   r_seq;
  logic [15:0]   r_drop_cnt;
  logic          w_cap_allowed;
  logic          w_capture;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_st_armed;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic: any capture attempt carrying the halt idiom freezes capture
  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = c_st_armed;
    end else begin
      case (r_state)
        c_st_armed:  if (cap_en) w_state_nxt = (inst_in == HALT_INST) ? c_st_halted : c_st_run;
        c_st_run:    if (cap_en && (inst_in == HALT_INST)) w_state_nxt = c_st_halted;
        c_st_halted: w_state_nxt = c_st_halted;
        default:     w_state_nxt = c_st_armed;
      endcase
    end
  end

  // Output logic
  always_comb begin
    halted        = (r_state == c_st_halted);
    w_cap_allowed = (r_state != c_st_halted);
  end

  assign full      = (r_count == c_depth);
  assign rd_valid  = (r_count != '0);
  assign w_capture = cap_en && w_cap_allowed && !clear;
  assign w_pop     = rd_valid && rd_ready && !clear;
  // A simultaneous pop frees the slot the push needs when full
  assign w_push    = w_capture && (!full || w_pop);
  assign w_drop    = w_capture && full && !w_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_pc[i]   <= '0;
        r_mem_inst[i] <= '0;
        r_mem_seq[i]  <= '0;
      end
    end else if (w_push) begin
      r_mem_pc[r_wr_ptr]   <= pc_in;
      r_mem_inst[r_wr_ptr] <= inst_in;
      r_mem_seq[r_wr_ptr]  <= r_seq;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_seq      <= '0;
      r_drop_cnt <= '0;
    end else if (clear) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_seq      <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_push)    r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_capture) r_seq    <= r_seq + 1'b1;
      if (w_drop && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign rd_pc    = r_mem_pc[r_rd_ptr];
  assign rd_inst  = r_mem_inst[r_rd_ptr];
  assign rd_seq   = r_mem_seq[r_rd_ptr];
  assign count    = r_count;
  assign drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_retire_trace_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_retire_trace_fifo
// Purpose  : Scoreboard bench for retire_trace_fifo with directed vectors.
// Revision : 1.0
// ============================================================================
module tb_retire_trace_fifo;

  localparam int          c_depth = 16;
  localparam logic [31:0] c_halt  = 32'h0000006F;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_in;
  logic [31:0] inst_in;
  logic        cap_en;
  logic        clear;
  logic        rd_ready;
  logic        rd_valid;
  logic [31:0] rd_pc;
  logic [31:0] rd_inst;
  logic [15:0] rd_seq;
  logic [4:0]  count;
  logic        full;
  logic [15:0] drop_cnt;
  logic        halted;

  retire_trace_fifo #(.DEPTH(16), .AW(4), .HALT_INST(32'h0000006F)) dut (
    .clk(clk), .rst_n(rst_n), .pc_in(pc_in), .inst_in(inst_in),
    .cap_en(cap_en), .clear(clear), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_inst(rd_inst), .rd_seq(rd_seq),
    .count(count), .full(full), .drop_cnt(drop_cnt), .halted(halted)
  );

  always #5 clk = ~clk;

  int unsigned   n_checks = 0;
  int unsigned   n_fail   = 0;
  logic [79:0]   sb[$];
  int            m_count;
  logic [15:0]   m_seq;
  logic [15:0]   m_drop;
  bit            m_halted;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Monitor: every accepted head entry must match the oldest expected entry
  always @(negedge clk) begin
    if (rst_n && !clear && rd_valid && rd_ready) begin
      if (sb.size() == 0) begin
        chk("pop_unexpected", 32'(rd_seq), 32'hFFFF_FFFF);
      end else begin
        logic [79:0] e;
        e = sb.pop_front();
        chk("pop_pc",   rd_pc,         e[79:48]);
        chk("pop_inst", rd_inst,       e[47:16]);
        chk("pop_seq",  32'(rd_seq),   32'(e[15:0]));
      end
    end
  end

  task automatic model_reset();
    sb.delete();
    m_count  = 0;
    m_seq    = '0;
    m_drop   = '0;
    m_halted = 1'b0;
  endtask

  task automatic step(input bit cap, input logic [31:0] pc, input logic [31:0] inst, input bit rdy);
    bit pop;
    bit push;
    cap_en   = cap;
    pc_in    = pc;
    inst_in  = inst;
    rd_ready = rdy;
    pop  = rdy && (m_count > 0);
    push = 1'b0;
    if (cap && !m_halted) begin
      if ((m_count < c_depth) || pop) begin
        sb.push_back({pc, inst, m_seq});
        push = 1'b1;
      end else if (m_drop != 16'hFFFF) begin
        m_drop++;
      end
      m_seq++;
      if (inst == c_halt) m_halted = 1'b1;
    end
    m_count = m_count + int'(push) - int'(pop);
    @(posedge clk); #1;
    chk("count",    32'(count),    32'(m_count));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    chk("halted",   32'(halted),   32'(m_halted));
    chk("rd_valid", 32'(rd_valid), 32'(m_count > 0));
    chk("full",     32'(full),     32'(m_count == c_depth));
  endtask

  task automatic do_clear();
    clear    = 1'b1;
    cap_en   = 1'b1;
    pc_in    = 32'hDEAD_0000;
    inst_in  = 32'h0000_0013;
    rd_ready = 1'b1;
    @(posedge clk); #1;
    clear  = 1'b0;
    cap_en = 1'b0;
    model_reset();
    chk("clr_count",    32'(count),    32'd0);
    chk("clr_rd_valid", 32'(rd_valid), 32'd0);
    chk("clr_halted",   32'(halted),   32'd0);
    chk("clr_drop",     32'(drop_cnt), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; pc_in = '0; inst_in = '0; cap_en = 1'b0; clear = 1'b0; rd_ready = 1'b0;
    model_reset();
    #12;
    chk("rst_count",    32'(count),    32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_full",     32'(full),     32'd0);
    chk("rst_rd_pc",    rd_pc,         32'd0);
    chk("rst_rd_inst",  rd_inst,       32'd0);
    chk("rst_rd_seq",   32'(rd_seq),   32'd0);
    chk("rst_halted",   32'(halted),   32'd0);
    chk("rst_drop",     32'(drop_cnt), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic capture and in-order drain
    step(1, 32'h0, 32'h00500093, 0);
    step(1, 32'h4, 32'h00A00113, 0);
    step(1, 32'h8, 32'h002081B3, 0);
    chk("t1_count",   32'(count),  32'd3);
    chk("t1_rd_pc",   rd_pc,       32'h0);
    chk("t1_rd_inst", rd_inst,     32'h00500093);
    chk("t1_rd_seq",  32'(rd_seq), 32'd0);
    for (int i = 0; i < 3; i++) step(0, 32'h0, 32'h0, 1);
    chk("t1_empty", 32'(rd_valid), 32'd0);

    // Overflow: 20 captures into 16 slots
    do_clear();
    for (int i = 0; i < 20; i++) step(1, 32'(4 * i), 32'h13 + 32'(i << 7), 0);
    chk("fill_full",  32'(full),     32'd1);
    chk("fill_count", 32'(count),    32'd16);
    chk("fill_drop",  32'(drop_cnt), 32'd4);
    chk("fill_head",  32'(rd_seq),   32'd0);
    step(1, 32'h50, 32'h13, 1);
    chk("fill_pp_count", 32'(count),    32'd16);
    chk("fill_pp_drop",  32'(drop_cnt), 32'd4);
    for (int i = 0; i < 14; i++) step(0, 32'h0, 32'h0, 1);
    chk("fill_tail_seq", 32'(rd_seq), 32'd15);
    chk("fill_tail_cnt", 32'(count),  32'd2);

    // Halt freezes capture
    step(1, 32'h24, c_halt, 0);
    chk("halt_set",   32'(halted), 32'd1);
    chk("halt_count", 32'(count),  32'd3);
    for (int i = 0; i < 5; i++) step(1, 32'h28 + 32'(4 * i), 32'h13, 0);
    chk("halt_frozen", 32'(count), 32'd3);

    // Clear while halted, then sequence restarts at 0
    do_clear();
    step(1, 32'h100, 32'h13, 0);
    chk("post_clr_seq", 32'(rd_seq), 32'd0);
    chk("post_clr_pc",  rd_pc,       32'h100);

    // Asynchronous reset between edges
    for (int i = 1; i < 5; i++) step(1, 32'h100 + 32'(4 * i), 32'h13, 0);
    chk("pre_rst_count", 32'(count), 32'd5);
    cap_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_count",    32'(count),    32'd0);
    chk("arst_rd_valid", 32'(rd_valid), 32'd0);
    chk("arst_rd_pc",    rd_pc,         32'd0);
    model_reset();
    #3;
    rst_n = 1'b1;
    step(0, 32'h200, 32'h13, 0);
    step(0, 32'h204, 32'h13, 0);
    chk("arst_idle", 32'(count), 32'd0);

    // Full-throughput streaming across two pointer wraps
    for (int i = 0; i < 40; i++) begin
      step(1, 32'h1000 + 32'(4 * i), 32'h13 + 32'(i << 7), 1);
      chk("wrap_count_le1", 32'(count <= 5'd1), 32'd1);
    end
    chk("wrap_drop", 32'(drop_cnt), 32'd0);
    chk("wrap_seq_tail", 32'(rd_seq), 32'd39);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
